// File: rtl/bp_me_axi_manager.sv
// BedRock Stream mem_fwd/mem_rev to AXI4 manager bridge.
// One read or write transaction in flight at a time, responses returned strictly in order.
module bp_me_axi_manager #(
    parameter int unsigned bedrock_fill_width_p    = 64,
    parameter int unsigned m_axi_data_width_p      = 64,
    parameter int unsigned m_axi_addr_width_p      = 64,
    parameter int unsigned m_axi_id_width_p        = 1,
    parameter int unsigned mem_fwd_header_width_lp = 59,
    parameter int unsigned mem_rev_header_width_lp = 59
) (
    input  logic                                clk_i,
    input  logic                                reset_i,

    input  logic [mem_fwd_header_width_lp-1:0]  mem_fwd_header_i,
    input  logic [bedrock_fill_width_p-1:0]     mem_fwd_data_i,
    input  logic                                mem_fwd_v_i,
    output logic                                mem_fwd_ready_and_o,

    output logic [mem_rev_header_width_lp-1:0]  mem_rev_header_o,
    output logic [bedrock_fill_width_p-1:0]     mem_rev_data_o,
    output logic                                mem_rev_v_o,
    input  logic                                mem_rev_ready_and_i,

    output logic [m_axi_addr_width_p-1:0]       m_axi_awaddr_o,
    output logic                                m_axi_awvalid_o,
    input  logic                                m_axi_awready_i,
    output logic [m_axi_id_width_p-1:0]         m_axi_awid_o,
    output logic                                m_axi_awlock_o,
    output logic [3:0]                          m_axi_awcache_o,
    output logic [2:0]                          m_axi_awprot_o,
    output logic [7:0]                          m_axi_awlen_o,
    output logic [2:0]                          m_axi_awsize_o,
    output logic [1:0]                          m_axi_awburst_o,
    output logic [3:0]                          m_axi_awqos_o,
    output logic [3:0]                          m_axi_awregion_o,

    output logic [m_axi_data_width_p-1:0]       m_axi_wdata_o,
    output logic [m_axi_data_width_p/8-1:0]     m_axi_wstrb_o,
    output logic                                m_axi_wlast_o,
    output logic                                m_axi_wvalid_o,
    input  logic                                m_axi_wready_i,

    input  logic [m_axi_id_width_p-1:0]         m_axi_bid_i,
    input  logic [1:0]                          m_axi_bresp_i,
    input  logic                                m_axi_bvalid_i,
    output logic                                m_axi_bready_o,

    output logic [m_axi_addr_width_p-1:0]       m_axi_araddr_o,
    output logic                                m_axi_arvalid_o,
    input  logic                                m_axi_arready_i,
    output logic [m_axi_id_width_p-1:0]         m_axi_arid_o,
    output logic                                m_axi_arlock_o,
    output logic [3:0]                          m_axi_arcache_o,
    output logic [2:0]                          m_axi_arprot_o,
    output logic [7:0]                          m_axi_arlen_o,
    output logic [2:0]                          m_axi_arsize_o,
    output logic [1:0]                          m_axi_arburst_o,
    output logic [3:0]                          m_axi_arqos_o,
    output logic [3:0]                          m_axi_arregion_o,

    input  logic [m_axi_data_width_p-1:0]       m_axi_rdata_i,
    input  logic [m_axi_id_width_p-1:0]         m_axi_rid_i,
    input  logic [1:0]                          m_axi_rresp_i,
    input  logic                                m_axi_rlast_i,
    input  logic                                m_axi_rvalid_i,
    output logic                                m_axi_rready_o
);

    typedef struct packed {
        logic [7:0]  payload;
        logic [2:0]  size;
        logic [39:0] addr;
        logic [3:0]  subop;
        logic [3:0]  msg_type;
    } bp_hdr_s;

    typedef enum logic [2:0] {
        e_ready, e_write, e_wresp, e_wack, e_read_addr, e_read_data
    } state_e;

    localparam logic [3:0] e_bedrock_mem_wr = 4'b0001;

    state_e     r_state, w_state_n;
    bp_hdr_s    w_fwd_hdr, r_hdr;

    logic [7:0] w_len, r_len;
    logic [2:0] w_axsize, r_size;
    logic [7:0] w_strb, r_strb;
    logic [5:0] w_align_mask;
    logic [3:0] r_cache;
    logic [1:0] r_burst;
    logic [2:0] r_cnt;
    logic       r_aw_done, r_w_done, r_fwd_taken;
    logic       w_aw_hs, w_w_hs, w_aw_done_now, w_w_done_now;
    logic [63:0] w_rshift, w_rdata_fmt;

    // Size decode of the incoming header: burst length, beat size, narrow strobe
    always_comb begin
        w_fwd_hdr = bp_hdr_s'(mem_fwd_header_i);
        w_len     = 8'd0;
        w_strb    = 8'hFF;
        case (w_fwd_hdr.size)
            3'd0:    w_strb = 8'h01 << w_fwd_hdr.addr[2:0];
            3'd1:    w_strb = 8'h03 << w_fwd_hdr.addr[2:0];
            3'd2:    w_strb = 8'h0F << w_fwd_hdr.addr[2:0];
            3'd4:    w_len  = 8'd1;
            3'd5:    w_len  = 8'd3;
            3'd6:    w_len  = 8'd7;
            3'd7:    w_len  = 8'd15;
            default: w_len  = 8'd0;
        endcase
        w_axsize     = (w_fwd_hdr.size > 3'd3) ? 3'd3 : w_fwd_hdr.size;
        w_align_mask = 6'((8'd1 << w_fwd_hdr.size) - 8'd1);
    end

    assign w_aw_hs       = m_axi_awvalid_o & m_axi_awready_i;
    assign w_w_hs        = m_axi_wvalid_o & m_axi_wready_i;
    assign w_aw_done_now = r_aw_done | w_aw_hs;
    assign w_w_done_now  = r_w_done | (w_w_hs & m_axi_wlast_o);

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= e_ready;
        else         r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_ready:     if (mem_fwd_v_i)
                             w_state_n = (w_fwd_hdr.msg_type == e_bedrock_mem_wr) ? e_write : e_read_addr;
            e_write:     if (w_aw_done_now && w_w_done_now) w_state_n = e_wresp;
            e_wresp:     if (m_axi_bvalid_i) w_state_n = e_wack;
            e_wack:      if (mem_rev_ready_and_i) w_state_n = e_ready;
            e_read_addr: if (m_axi_arready_i) w_state_n = e_read_data;
            e_read_data: if (m_axi_rvalid_i && mem_rev_ready_and_i && m_axi_rlast_i) w_state_n = e_ready;
            default:     w_state_n = e_ready;
        endcase
    end

    // Narrow reads: move the addressed bytes down and replicate them across the word
    always_comb begin
        w_rshift = m_axi_rdata_i >> {r_hdr.addr[2:0], 3'b000};
        case (r_hdr.size)
            3'd0:    w_rdata_fmt = {8{w_rshift[7:0]}};
            3'd1:    w_rdata_fmt = {4{w_rshift[15:0]}};
            3'd2:    w_rdata_fmt = {2{w_rshift[31:0]}};
            default: w_rdata_fmt = m_axi_rdata_i;
        endcase
    end

    always_comb begin
        m_axi_awvalid_o     = 1'b0;
        m_axi_wvalid_o      = 1'b0;
        m_axi_wlast_o       = 1'b0;
        m_axi_bready_o      = 1'b0;
        m_axi_arvalid_o     = 1'b0;
        m_axi_rready_o      = 1'b0;
        mem_fwd_ready_and_o = 1'b0;
        mem_rev_v_o         = 1'b0;
        mem_rev_data_o      = '0;
        case (r_state)
            e_write: begin
                m_axi_awvalid_o     = ~r_aw_done;
                m_axi_wvalid_o      = mem_fwd_v_i & ~r_w_done;
                mem_fwd_ready_and_o = m_axi_wready_i & ~r_w_done;
                m_axi_wlast_o       = (r_cnt == r_len[2:0]);
            end
            e_wresp:     m_axi_bready_o = 1'b1;
            e_wack:      mem_rev_v_o    = 1'b1;
            e_read_addr: begin
                m_axi_arvalid_o     = 1'b1;
                mem_fwd_ready_and_o = ~r_fwd_taken;
            end
            e_read_data: begin
                mem_rev_v_o    = m_axi_rvalid_i;
                m_axi_rready_o = mem_rev_ready_and_i;
                mem_rev_data_o = bedrock_fill_width_p'(w_rdata_fmt);
            end
            default: ;
        endcase
    end

    // Header latch, W beat counter and per-channel completion flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hdr       <= '0;
            r_len       <= 8'd0;
            r_size      <= 3'd0;
            r_strb      <= 8'd0;
            r_cache     <= 4'd0;
            r_burst     <= 2'd0;
            r_cnt       <= 3'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_fwd_taken <= 1'b0;
        end else begin
            if (r_state == e_ready && mem_fwd_v_i) begin
                r_hdr       <= w_fwd_hdr;
                r_len       <= w_len;
                r_size      <= w_axsize;
                r_strb      <= w_strb;
                r_cache     <= 4'b0011;
                r_burst     <= 2'b01;
                r_cnt       <= 3'd0;
                r_aw_done   <= 1'b0;
                r_w_done    <= 1'b0;
                r_fwd_taken <= 1'b0;
            end
            if (r_state == e_write) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs) begin
                    if (m_axi_wlast_o) begin
                        r_cnt    <= 3'd0;
                        r_w_done <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end
            end
            if (r_state == e_read_addr && mem_fwd_v_i && mem_fwd_ready_and_o)
                r_fwd_taken <= 1'b1;
        end
    end

    assign mem_rev_header_o = mem_rev_header_width_lp'(r_hdr);
    assign m_axi_wdata_o    = m_axi_data_width_p'(mem_fwd_data_i);
    assign m_axi_wstrb_o    = r_strb;

    assign m_axi_awaddr_o   = m_axi_addr_width_p'(r_hdr.addr);
    assign m_axi_awid_o     = '0;
    assign m_axi_awlock_o   = 1'b0;
    assign m_axi_awcache_o  = r_cache;
    assign m_axi_awprot_o   = 3'd0;
    assign m_axi_awlen_o    = r_len;
    assign m_axi_awsize_o   = r_size;
    assign m_axi_awburst_o  = r_burst;
    assign m_axi_awqos_o    = 4'd0;
    assign m_axi_awregion_o = 4'd0;

    assign m_axi_araddr_o   = m_axi_addr_width_p'(r_hdr.addr);
    assign m_axi_arid_o     = '0;
    assign m_axi_arlock_o   = 1'b0;
    assign m_axi_arcache_o  = r_cache;
    assign m_axi_arprot_o   = 3'd0;
    assign m_axi_arlen_o    = r_len;
    assign m_axi_arsize_o   = r_size;
    assign m_axi_arburst_o  = r_burst;
    assign m_axi_arqos_o    = 4'd0;
    assign m_axi_arregion_o = 4'd0;

    // Error responses are forwarded as-is; these only flag them in simulation
    a_addr_aligned: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_ready && mem_fwd_v_i) |-> ((w_fwd_hdr.addr[5:0] & w_align_mask) == 6'd0));
    a_bresp_okay: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_wresp && m_axi_bvalid_i) |-> (m_axi_bresp_i == 2'b00 && m_axi_bid_i == '0));
    a_rresp_okay: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_read_data && m_axi_rvalid_i) |-> (m_axi_rresp_i == 2'b00 && m_axi_rid_i == '0));

endmodule

// File: tb/tb_bp_me_axi_manager.sv
// Directed bench for bp_me_axi_manager: the bench plays both the BedRock
// client and the AXI subordinate, cycle by cycle.
module tb_bp_me_axi_manager;

    localparam logic [3:0] RD = 4'b0000;
    localparam logic [3:0] WR = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [58:0] fwd_hdr;
    logic [63:0] fwd_data;
    logic        fwd_v, fwd_ready;
    logic [58:0] rev_hdr;
    logic [63:0] rev_data;
    logic        rev_v, rev_ready;
    logic [63:0] awaddr, araddr;
    logic        awvalid, awready, arvalid, arready;
    logic [0:0]  awid, arid, bid, rid;
    logic        awlock, arlock;
    logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
    logic [2:0]  awprot, arprot, awsize, arsize;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready;
    logic        rlast, rvalid, rready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_me_axi_manager dut (
        .clk_i(clk), .reset_i(reset),
        .mem_fwd_header_i(fwd_hdr), .mem_fwd_data_i(fwd_data),
        .mem_fwd_v_i(fwd_v), .mem_fwd_ready_and_o(fwd_ready),
        .mem_rev_header_o(rev_hdr), .mem_rev_data_o(rev_data),
        .mem_rev_v_o(rev_v), .mem_rev_ready_and_i(rev_ready),
        .m_axi_awaddr_o(awaddr), .m_axi_awvalid_o(awvalid), .m_axi_awready_i(awready),
        .m_axi_awid_o(awid), .m_axi_awlock_o(awlock), .m_axi_awcache_o(awcache),
        .m_axi_awprot_o(awprot), .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
        .m_axi_awburst_o(awburst), .m_axi_awqos_o(awqos), .m_axi_awregion_o(awregion),
        .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast),
        .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
        .m_axi_bid_i(bid), .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready),
        .m_axi_araddr_o(araddr), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_arid_o(arid), .m_axi_arlock_o(arlock), .m_axi_arcache_o(arcache),
        .m_axi_arprot_o(arprot), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
        .m_axi_arburst_o(arburst), .m_axi_arqos_o(arqos), .m_axi_arregion_o(arregion),
        .m_axi_rdata_i(rdata), .m_axi_rid_i(rid), .m_axi_rresp_i(rresp),
        .m_axi_rlast_i(rlast), .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    function automatic logic [58:0] mk_hdr(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz);
        return {8'hA5, sz, a, 4'h0, t};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [58:0] h, hr;
        int k, cyc;
        logic acc;

        reset = 1'b1; fwd_hdr = '0; fwd_data = '0; fwd_v = 1'b0; rev_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rid = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_fwd_ready", 64'(fwd_ready), 64'd0);
        check("rst_rev_v", 64'(rev_v), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_awlen", 64'(awlen), 64'd0);
        reset = 1'b0;

        // 8-byte write to 0x8000_0010
        h = mk_hdr(WR, 40'h80000010, 3'd3);
        fwd_hdr = h; fwd_data = 64'hDEADBEEF_CAFEF00D; fwd_v = 1'b1;
        #1;
        check("t1_idle_ready", 64'(fwd_ready), 64'd0);
        check("t1_idle_aw", 64'(awvalid), 64'd0);
        @(negedge clk);
        check("t1_awvalid", 64'(awvalid), 64'd1);
        check("t1_awaddr", awaddr, 64'h80000010);
        check("t1_awlen", 64'(awlen), 64'd0);
        check("t1_awsize", 64'(awsize), 64'd3);
        check("t1_awburst", 64'(awburst), 64'd1);
        check("t1_awcache", 64'(awcache), 64'd3);
        check("t1_wstrb", 64'(wstrb), 64'hFF);
        check("t1_wlast", 64'(wlast), 64'd1);
        check("t1_wvalid", 64'(wvalid), 64'd1);
        check("t1_wdata", wdata, 64'hDEADBEEF_CAFEF00D);
        check("t1_fwd_ready_noready", 64'(fwd_ready), 64'd0);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        fwd_v = 1'b0; awready = 1'b0; wready = 1'b0;
        check("t1_bready", 64'(bready), 64'd1);
        check("t1_aw_dropped", 64'(awvalid), 64'd0);
        check("t1_no_rev_yet", 64'(rev_v), 64'd0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("t1_rev_v", 64'(rev_v), 64'd1);
        check("t1_rev_hdr", 64'(rev_hdr), 64'(h));
        check("t1_rev_data", rev_data, 64'd0);
        rev_ready = 1'b1;
        @(negedge clk);
        rev_ready = 1'b0;
        check("t1_rev_done", 64'(rev_v), 64'd0);

        // 64-byte write, AW accepted only after 5 cycles while W streams
        h = mk_hdr(WR, 40'h40, 3'd6);
        fwd_hdr = h; fwd_data = '0; fwd_v = 1'b1; wready = 1'b1; awready = 1'b0;
        @(negedge clk);
        check("t2_awlen", 64'(awlen), 64'd7);
        check("t2_awsize", 64'(awsize), 64'd3);
        for (int i = 0; i < 8; i++) begin
            fwd_data = 64'(i);
            awready  = (i == 5);
            #1;
            check("t2_wvalid", 64'(wvalid), 64'd1);
            check("t2_wdata", wdata, 64'(i));
            check("t2_wlast", 64'(wlast), 64'(i == 7));
            check("t2_fwd_ready", 64'(fwd_ready), 64'd1);
            check("t2_awvalid", 64'(awvalid), 64'(i <= 5));
            check("t2_no_rev", 64'(rev_v), 64'd0);
            @(negedge clk);
        end
        fwd_v = 1'b0; awready = 1'b0; wready = 1'b0;
        check("t2_bready", 64'(bready), 64'd1);
        check("t2_fwd_ready_wresp", 64'(fwd_ready), 64'd0);
        @(negedge clk);
        check("t2_no_rev_before_b", 64'(rev_v), 64'd0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        check("t2_rev_v", 64'(rev_v), 64'd1);
        check("t2_rev_hdr", 64'(rev_hdr), 64'(h));
        rev_ready = 1'b1;
        @(negedge clk);
        rev_ready = 1'b0;

        // 2-byte read at 0x1006
        h = mk_hdr(RD, 40'h1006, 3'd1);
        fwd_hdr = h; fwd_data = 64'hFFFF; fwd_v = 1'b1;
        @(negedge clk);
        check("t3_arvalid", 64'(arvalid), 64'd1);
        check("t3_araddr", araddr, 64'h1006);
        check("t3_arsize", 64'(arsize), 64'd1);
        check("t3_arlen", 64'(arlen), 64'd0);
        check("t3_consume", 64'(fwd_ready), 64'd1);
        check("t3_no_aw", 64'(awvalid), 64'd0);
        @(negedge clk);
        fwd_v = 1'b0;
        check("t3_consumed_once", 64'(fwd_ready), 64'd0);
        check("t3_ar_held", 64'(arvalid), 64'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("t3_ar_dropped", 64'(arvalid), 64'd0);
        rdata = 64'h1122_3344_5566_7788; rvalid = 1'b1; rlast = 1'b1; rev_ready = 1'b1;
        #1;
        check("t3_rev_v", 64'(rev_v), 64'd1);
        check("t3_rready", 64'(rready), 64'd1);
        check("t3_rev_data", rev_data, 64'h1122_1122_1122_1122);
        check("t3_rev_hdr", 64'(rev_hdr), 64'(h));
        @(negedge clk);
        check("t3_back_to_ready", 64'(rev_v), 64'd0);
        rvalid = 1'b0; rlast = 1'b0; rev_ready = 1'b0;

        // 32-byte read with rev ready toggling every cycle
        h = mk_hdr(RD, 40'h100, 3'd5);
        fwd_hdr = h; fwd_v = 1'b1;
        @(negedge clk);
        check("t4_arlen", 64'(arlen), 64'd3);
        check("t4_arsize", 64'(arsize), 64'd3);
        arready = 1'b1;
        @(negedge clk);
        fwd_v = 1'b0; arready = 1'b0;
        k = 0; cyc = 0; rev_ready = 1'b0;
        while (k < 4 && cyc < 20) begin
            rvalid = 1'b1; rdata = 64'h1000 + 64'(k); rlast = (k == 3);
            #1;
            check("t4_rready", 64'(rready), 64'(rev_ready));
            check("t4_rev_v", 64'(rev_v), 64'd1);
            check("t4_rev_data", rev_data, 64'h1000 + 64'(k));
            acc = rev_ready;
            @(negedge clk);
            if (acc) k++;
            rev_ready = ~rev_ready;
            cyc++;
        end
        check("t4_beats", 64'(k), 64'd4);
        #1;
        check("t4_done_rev_v", 64'(rev_v), 64'd0);
        check("t4_done_rready", 64'(rready), 64'd0);
        rvalid = 1'b0; rlast = 1'b0; rev_ready = 1'b0;

        // 1-byte write at offset 5
        h = mk_hdr(WR, 40'h2005, 3'd0);
        fwd_hdr = h; fwd_data = 64'h0000_AB00_0000_0000; fwd_v = 1'b1;
        @(negedge clk);
        check("t5_wstrb", 64'(wstrb), 64'h20);
        check("t5_awsize", 64'(awsize), 64'd0);
        check("t5_awlen", 64'(awlen), 64'd0);
        check("t5_wlast", 64'(wlast), 64'd1);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        fwd_v = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        check("t5_bready", 64'(bready), 64'd1);
        @(negedge clk);
        bvalid = 1'b0;
        check("t5_rev_v", 64'(rev_v), 64'd1);
        rev_ready = 1'b1;
        @(negedge clk);
        rev_ready = 1'b0;

        // Write followed immediately by a read: AR must wait for the write rev handshake
        h  = mk_hdr(WR, 40'h3000, 3'd3);
        hr = mk_hdr(RD, 40'h3008, 3'd3);
        fwd_hdr = h; fwd_data = 64'h5555; fwd_v = 1'b1;
        @(negedge clk);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; fwd_hdr = hr; bvalid = 1'b1;
        check("t6_wresp_no_consume", 64'(fwd_ready), 64'd0);
        @(negedge clk);
        bvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_ar_blocked", 64'(arvalid), 64'd0);
            check("t6_wack_rev_v", 64'(rev_v), 64'd1);
            @(negedge clk);
        end
        rev_ready = 1'b1;
        @(negedge clk);
        rev_ready = 1'b0;
        check("t6_ar_not_yet", 64'(arvalid), 64'd0);
        @(negedge clk);
        check("t6_arvalid", 64'(arvalid), 64'd1);
        check("t6_araddr", araddr, 64'h3008);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; fwd_v = 1'b0;
        rdata = 64'hA5A5_0000_FFFF_1234; rvalid = 1'b1; rlast = 1'b1; rev_ready = 1'b1;
        #1;
        check("t6_rev_data", rev_data, 64'hA5A5_0000_FFFF_1234);
        check("t6_rev_hdr", 64'(rev_hdr), 64'(hr));
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rev_ready = 1'b0;

        // Reset while in e_read_data, then a fresh read
        h = mk_hdr(RD, 40'h4000, 3'd3);
        fwd_hdr = h; fwd_v = 1'b1;
        @(negedge clk);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; fwd_v = 1'b0;
        rdata = 64'h7777; rvalid = 1'b1; rlast = 1'b1; rev_ready = 1'b0;
        #1;
        check("t7_in_read_data", 64'(rev_v), 64'd1);
        reset = 1'b1; rev_ready = 1'b1;
        @(negedge clk);
        check("t7_rst_rev_v", 64'(rev_v), 64'd0);
        check("t7_rst_rready", 64'(rready), 64'd0);
        check("t7_rst_arvalid", 64'(arvalid), 64'd0);
        check("t7_rst_awvalid", 64'(awvalid), 64'd0);
        check("t7_rst_wvalid", 64'(wvalid), 64'd0);
        check("t7_rst_fwd_ready", 64'(fwd_ready), 64'd0);
        check("t7_rst_bready", 64'(bready), 64'd0);
        reset = 1'b0; rvalid = 1'b0; rlast = 1'b0; rev_ready = 1'b0;
        h = mk_hdr(RD, 40'h4010, 3'd3);
        fwd_hdr = h; fwd_v = 1'b1;
        @(negedge clk);
        check("t7_new_arvalid", 64'(arvalid), 64'd1);
        check("t7_new_araddr", araddr, 64'h4010);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; fwd_v = 1'b0;
        rdata = 64'h0123_4567_89AB_CDEF; rvalid = 1'b1; rlast = 1'b1; rev_ready = 1'b1;
        #1;
        check("t7_new_rev_v", 64'(rev_v), 64'd1);
        check("t7_new_rev_data", rev_data, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("t7_new_done", 64'(rev_v), 64'd0);
        rvalid = 1'b0; rlast = 1'b0; rev_ready = 1'b0;

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
